// File: rtl/mips_sim_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_sim_pkg
// Description : Shared types and constants for the data-memory write checker.
//               Run-state encoding, the default success signature, and the
//               store-log entry layout at the 16-bit core's widths.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_sim_pkg;

    // Run monitor states. PASS/FAIL/TOUT are terminal until the next start.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_PASS = 3'd2,
        ST_FAIL = 3'd3,
        ST_TOUT = 3'd4
    } run_state_t;

    // Test programs signal success by storing PASS_DATA_DEF to PASS_ADDR_DEF.
    localparam logic [15:0] PASS_ADDR_DEF = 16'h0054;
    localparam logic [15:0] PASS_DATA_DEF = 16'h0007;

    // Store-log entry at the 16-bit core's widths. Wider instances of the
    // log use the same {addr, data} layout at their own parameter widths.
    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } log_entry_t;

endpackage : mips_sim_pkg
`default_nettype wire

// File: rtl/store_log_ram.sv
`default_nettype none
// ============================================================================
// Module      : store_log_ram
// Description : Circular log of the most recent stores. Owns the write
//               pointer, the saturating entry count and a registered read
//               port addressed relative to the newest entry.
// Ports       : clk, reset (async, active-low)
//               i_clr      - clear pointer and entry count (run start)
//               i_we       - write {i_addr, i_data} at the pointer
//               i_rd_idx   - read index, 0 = most recent entry
//               o_rd_addr  - registered address of selected entry
//               o_rd_data  - registered data of selected entry
//               o_rd_valid - registered (i_rd_idx < entry count)
// Revision    : 1.0 - initial release
// ============================================================================
module store_log_ram #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int LOG_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_clr,
    input  logic                         i_we,
    input  logic [ADDR_W-1:0]            i_addr,
    input  logic [DATA_W-1:0]            i_data,
    input  logic [$clog2(LOG_DEPTH)-1:0] i_rd_idx,
    output logic [ADDR_W-1:0]            o_rd_addr,
    output logic [DATA_W-1:0]            o_rd_data,
    output logic                         o_rd_valid
);

    localparam int IDX_W = $clog2(LOG_DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] c_full = CNT_W'(LOG_DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t           r_mem [LOG_DEPTH];
    logic [IDX_W-1:0] r_wptr;
    logic [CNT_W-1:0] r_count;
    logic [IDX_W-1:0] w_rd_ptr;

    // Newest entry sits just below the write pointer; the depth is a power
    // of two so the subtraction wraps naturally.
    assign w_rd_ptr = r_wptr - IDX_W'(1) - i_rd_idx;

    // Storage carries no reset: contents are meaningless until counted.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[r_wptr] <= '{addr: i_addr, data: i_data};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_count <= '0;
        end else if (i_clr) begin
            r_wptr  <= '0;
            r_count <= '0;
        end else if (i_we) begin
            r_wptr <= r_wptr + IDX_W'(1);
            if (r_count != c_full) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    // Non-blocking read: a same-cycle write to the selected slot is not seen.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_rd_addr  <= '0;
            o_rd_data  <= '0;
            o_rd_valid <= 1'b0;
        end else begin
            o_rd_addr  <= r_mem[w_rd_ptr].addr;
            o_rd_data  <= r_mem[w_rd_ptr].data;
            o_rd_valid <= ({1'b0, i_rd_idx} < r_count);
        end
    end

endmodule : store_log_ram
`default_nettype wire

// File: rtl/mem_write_checker.sv
`default_nettype none
// ============================================================================
// Module      : mem_write_checker
// Description : Run monitor on the core's data-memory write bus. Decides
//               pass / fail / timeout from a signature store and keeps a
//               circular log of recent stores for post-run inspection.
// Ports       : clk, reset (async, active-low), start (run pulse)
//               memwrite/dataadr/writedata - observed store bus
//               done/pass/fail/timeout     - registered verdict
//               cycles/stores              - RUN cycle and store counters
//               log_idx -> log_addr/log_data/log_valid (1-cycle latency)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_write_checker
    import mips_sim_pkg::*;
#(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 16,
    parameter int                LOG_DEPTH = 8,
    parameter int                TIMEOUT   = 100,
    parameter logic [ADDR_W-1:0] PASS_ADDR = ADDR_W'(PASS_ADDR_DEF),
    parameter logic [DATA_W-1:0] PASS_DATA = DATA_W'(PASS_DATA_DEF),
    parameter int                CNT_W     = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         memwrite,
    input  logic [ADDR_W-1:0]            dataadr,
    input  logic [DATA_W-1:0]            writedata,
    output logic                         done,
    output logic                         pass,
    output logic                         fail,
    output logic                         timeout,
    output logic [CNT_W-1:0]             cycles,
    output logic [CNT_W-1:0]             stores,
    input  logic [$clog2(LOG_DEPTH)-1:0] log_idx,
    output logic [ADDR_W-1:0]            log_addr,
    output logic [DATA_W-1:0]            log_data,
    output logic                         log_valid
);

    localparam logic [CNT_W-1:0] c_tout_last = CNT_W'(TIMEOUT - 1);

    run_state_t       r_state;
    run_state_t       w_next_state;
    logic             w_in_run;
    logic             w_sig_addr;
    logic             w_log_we;
    logic [CNT_W-1:0] r_cycles;
    logic [CNT_W-1:0] r_stores;
    logic             r_done;
    logic             r_pass;
    logic             r_fail;
    logic             r_timeout;

    assign w_in_run   = (r_state == ST_RUN);
    assign w_sig_addr = memwrite && (dataadr == PASS_ADDR);
    // A start in RUN restarts the run, so that cycle's store is dropped.
    assign w_log_we   = w_in_run && memwrite && !start;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next_state = ST_RUN;
            end
            ST_RUN: begin
                // Signature store beats the timeout on the same edge.
                if (start)                                w_next_state = ST_RUN;
                else if (w_sig_addr && writedata == PASS_DATA) w_next_state = ST_PASS;
                else if (w_sig_addr)                      w_next_state = ST_FAIL;
                else if (r_cycles == c_tout_last)         w_next_state = ST_TOUT;
            end
            ST_PASS, ST_FAIL, ST_TOUT: begin
                if (start) w_next_state = ST_RUN;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Verdict flags registered alongside the state so they are glitch-free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_fail    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_pass    <= (w_next_state == ST_PASS);
            r_fail    <= (w_next_state == ST_FAIL);
            r_timeout <= (w_next_state == ST_TOUT);
            r_done    <= (w_next_state == ST_PASS) || (w_next_state == ST_FAIL) ||
                         (w_next_state == ST_TOUT);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cycles <= '0;
            r_stores <= '0;
        end else if (start) begin
            r_cycles <= '0;
            r_stores <= '0;
        end else if (w_in_run) begin
            if (r_cycles != '1) begin
                r_cycles <= r_cycles + CNT_W'(1);
            end
            if (memwrite && (r_stores != '1)) begin
                r_stores <= r_stores + CNT_W'(1);
            end
        end
    end

    store_log_ram #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .LOG_DEPTH (LOG_DEPTH)
    ) u_log (
        .clk        (clk),
        .reset      (reset),
        .i_clr      (start),
        .i_we       (w_log_we),
        .i_addr     (dataadr),
        .i_data     (writedata),
        .i_rd_idx   (log_idx),
        .o_rd_addr  (log_addr),
        .o_rd_data  (log_data),
        .o_rd_valid (log_valid)
    );

    assign done    = r_done;
    assign pass    = r_pass;
    assign fail    = r_fail;
    assign timeout = r_timeout;
    assign cycles  = r_cycles;
    assign stores  = r_stores;

endmodule : mem_write_checker
`default_nettype wire

// File: tb/tb_mem_write_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_write_checker
// Description : Directed self-checking bench for mem_write_checker with
//               TIMEOUT=20 and LOG_DEPTH=8. Inputs change 1 time unit after
//               the rising edge; outputs are sampled at the same point.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_write_checker;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 16;
    localparam int LOG_DEPTH = 8;
    localparam int TIMEOUT   = 20;
    localparam int CNT_W     = 16;

    logic              clk;
    logic              reset;
    logic              start;
    logic              memwrite;
    logic [ADDR_W-1:0] dataadr;
    logic [DATA_W-1:0] writedata;
    logic              done;
    logic              pass;
    logic              fail;
    logic              timeout;
    logic [CNT_W-1:0]  cycles;
    logic [CNT_W-1:0]  stores;
    logic [2:0]        log_idx;
    logic [ADDR_W-1:0] log_addr;
    logic [DATA_W-1:0] log_data;
    logic              log_valid;

    int n_checks = 0;
    int n_fail   = 0;

    mem_write_checker #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .LOG_DEPTH (LOG_DEPTH),
        .TIMEOUT   (TIMEOUT),
        .PASS_ADDR (16'h0054),
        .PASS_DATA (16'h0007),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .done      (done),
        .pass      (pass),
        .fail      (fail),
        .timeout   (timeout),
        .cycles    (cycles),
        .stores    (stores),
        .log_idx   (log_idx),
        .log_addr  (log_addr),
        .log_data  (log_data),
        .log_valid (log_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic store(input logic [15:0] a, input logic [15:0] d);
        memwrite  = 1'b1;
        dataadr   = a;
        writedata = d;
        tick();
        memwrite  = 1'b0;
        dataadr   = '0;
        writedata = '0;
    endtask

    task automatic read_log(input int k);
        log_idx = 3'(k);
        tick();
    endtask

    task automatic check_verdict(input string tag, input logic d, input logic p,
                                 input logic f, input logic t);
        check({tag, ".verdict"}, {28'd0, done, pass, fail, timeout}, {28'd0, d, p, f, t});
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; memwrite = 1'b0;
        dataadr = '0; writedata = '0; log_idx = '0;

        // Reset state
        #1;
        check_verdict("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset.cycles", 32'(cycles), 32'd0);
        check("reset.stores", 32'(stores), 32'd0);
        check("reset.log_valid", 32'(log_valid), 32'd0);
        idle(2);
        reset = 1'b1;
        tick();

        // Stores in IDLE are ignored
        store(16'h0054, 16'h0007);
        check_verdict("idle_store", 1'b0, 1'b0, 1'b0, 1'b0);
        check("idle_store.stores", 32'(stores), 32'd0);
        read_log(0);
        check("idle_store.log_valid", 32'(log_valid), 32'd0);

        // 1: pass signature on RUN cycle 12
        start_pulse();
        idle(3);
        store(16'h0010, 16'h00AA);
        idle(3);
        store(16'h0020, 16'h00BB);
        idle(4);
        check_verdict("t1.pre", 1'b0, 1'b0, 1'b0, 1'b0);
        store(16'h0054, 16'h0007);
        check_verdict("t1.pass", 1'b1, 1'b1, 1'b0, 1'b0);
        check("t1.cycles", 32'(cycles), 32'd13);
        check("t1.stores", 32'(stores), 32'd3);
        idle(2);
        check("t1.cycles_frozen", 32'(cycles), 32'd13);
        read_log(0);
        check("t1.log0", {log_addr, log_data}, 32'h0054_0007);
        check("t1.log0_valid", 32'(log_valid), 32'd1);
        read_log(1);
        check("t1.log1", {log_addr, log_data}, 32'h0020_00BB);
        read_log(2);
        check("t1.log2", {log_addr, log_data}, 32'h0010_00AA);
        read_log(3);
        check("t1.log3_valid", 32'(log_valid), 32'd0);

        // 2: wrong data at signature address
        start_pulse();
        check_verdict("t2.restart", 1'b0, 1'b0, 1'b0, 1'b0);
        check("t2.restart_cnt", {cycles, stores}, 32'd0);
        store(16'h0054, 16'h0003);
        check_verdict("t2.fail", 1'b1, 1'b0, 1'b1, 1'b0);
        store(16'h0054, 16'h0007);
        check_verdict("t2.sticky", 1'b1, 1'b0, 1'b1, 1'b0);
        check("t2.stores", 32'(stores), 32'd1);

        // 3: timeout after exactly TIMEOUT RUN cycles
        start_pulse();
        idle(TIMEOUT - 1);
        check_verdict("t3.pre", 1'b0, 1'b0, 1'b0, 1'b0);
        check("t3.cycles_pre", 32'(cycles), 32'd19);
        tick();
        check_verdict("t3.tout", 1'b1, 1'b0, 1'b0, 1'b1);
        check("t3.cycles", 32'(cycles), 32'd20);
        idle(3);
        check("t3.cycles_frozen", 32'(cycles), 32'd20);

        // 4: signature on the timeout cycle wins
        start_pulse();
        idle(TIMEOUT - 1);
        store(16'h0054, 16'h0007);
        check_verdict("t4.pass", 1'b1, 1'b1, 1'b0, 1'b0);
        check("t4.cycles", 32'(cycles), 32'd20);

        // 5: log wrap after 12 stores
        start_pulse();
        for (int i = 1; i <= 11; i++) store(16'(i), 16'(16'h0100 + i));
        store(16'h0054, 16'h0007);
        check_verdict("t5.pass", 1'b1, 1'b1, 1'b0, 1'b0);
        check("t5.stores", 32'(stores), 32'd12);
        for (int k = 0; k < LOG_DEPTH; k++) begin
            read_log(k);
            if (k == 0) check("t5.log0", {log_addr, log_data}, 32'h0054_0007);
            else        check($sformatf("t5.log%0d", k), {log_addr, log_data},
                              {16'(12 - k), 16'(16'h0100 + 12 - k)});
            check($sformatf("t5.valid%0d", k), 32'(log_valid), 32'd1);
        end

        // 6: asynchronous reset mid-run, then restart during RUN
        start_pulse();
        store(16'h0030, 16'h0001);
        log_idx = 3'd0;
        idle(2);
        check("t6.pre_stores", 32'(stores), 32'd1);
        check("t6.pre_valid", 32'(log_valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        check_verdict("t6.async", 1'b0, 1'b0, 1'b0, 1'b0);
        check("t6.async_cnt", {cycles, stores}, 32'd0);
        check("t6.async_valid", 32'(log_valid), 32'd0);
        #1 reset = 1'b1;
        tick();
        start_pulse();
        store(16'h0040, 16'h0011);
        store(16'h0041, 16'h0022);
        read_log(2);
        check("t6.idx2_valid", 32'(log_valid), 32'd0);
        read_log(1);
        check("t6.idx1", {31'd0, log_valid}, 32'd1);
        check("t6.idx1_entry", {log_addr, log_data}, 32'h0040_0011);
        check("t6.stores", 32'(stores), 32'd2);
        start_pulse();
        check("t6.restart_cnt", {cycles, stores}, 32'd0);
        check_verdict("t6.restart", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("t6.running", 32'(cycles), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mem_write_checker
`default_nettype wire
